// File: rtl/frog_renderer.sv
// rtl/frog_renderer.sv - Frogger-style game state plus registered RRRGGGBB pixel source for the VGA path
module frog_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int CELL         = 32,
    parameter int CAR_W        = 64,
    parameter int START_LIVES  = 3,
    parameter int DEATH_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [7:0] color_out,
    output logic       frame_tick,
    output logic [7:0] score,
    output logic [3:0] lives
);
    localparam int COLS      = H_ACTIVE / CELL;
    localparam int ROWS      = V_ACTIVE / CELL;
    localparam int START_COL = COLS / 2 - 1;
    localparam int START_ROW = ROWS - 1;
    localparam int DW        = $clog2(DEATH_FRAMES + 1);

    localparam logic [7:0] C_GOAL  = 8'b00000011;
    localparam logic [7:0] C_ROAD  = 8'b01001001;
    localparam logic [7:0] C_FROG  = 8'b00011100;
    localparam logic [7:0] C_DEAD  = 8'b11111100;
    localparam logic [7:0] C_CAR   = 8'b11100000;
    localparam logic [7:0] C_OVER  = 8'b11100000;

    typedef enum logic [1:0] {S_PLAY, S_DEAD, S_OVER} state_t;
    typedef enum logic [2:0] {MV_NONE, MV_UP, MV_DOWN, MV_LEFT, MV_RIGHT} move_t;

    state_t        state_q, state_d;
    move_t         move_q, move_d;
    logic [3:0]    btn_q, btn_d, btn_rise;
    logic [4:0]    col_q, col_d;
    logic [3:0]    row_q, row_d;
    logic [9:0]    car_q [4];
    logic [9:0]    car_d [4];
    logic [DW-1:0] death_q, death_d;
    logic [7:0]    score_q, score_d, color_q, color_d;
    logic [3:0]    lives_q, lives_d;
    logic          vs_q, vs_d, tick_q, tick_d, check_q, check_d;

    // Even lanes drift right, odd lanes left; speed is lane+1 px per frame.
    function automatic logic [9:0] car_step(input logic [9:0] x, input int lane);
        logic [10:0] spd;
        logic [10:0] wide;
        spd  = 11'(lane + 1);
        wide = {1'b0, x};
        if (lane % 2 == 0)
            wide = (wide + spd >= 11'(H_ACTIVE)) ? wide + spd - 11'(H_ACTIVE) : wide + spd;
        else
            wide = (wide < spd) ? wide + 11'(H_ACTIVE) - spd : wide - spd;
        return wide[9:0];
    endfunction

    logic        vis, frog_pix, car_pix, pix_road;
    logic [4:0]  pix_col;
    logic [3:0]  pix_row;
    logic [1:0]  pix_lane;
    logic [10:0] px, pcx, pend;

    always_comb begin
        vis      = (next_x < 10'(H_ACTIVE)) && (next_y < 10'(V_ACTIVE));
        pix_col  = 5'(next_x / 10'(CELL));
        pix_row  = 4'(next_y / 10'(CELL));
        pix_lane = 2'(pix_row - 4'd10);
        pix_road = (pix_row >= 4'd10) && (pix_row <= 4'd13);
        px       = {1'b0, next_x};
        pcx      = {1'b0, car_q[pix_lane]};
        pend     = pcx + 11'(CAR_W);
        car_pix  = pix_road && (((px >= pcx) && (px < pend)) ||
                   ((pend > 11'(H_ACTIVE)) && (px < pend - 11'(H_ACTIVE))));
        frog_pix = (pix_col == col_q) && (pix_row == row_q);
        color_d  = 8'h00;
        if (vis) begin
            if (state_q == S_OVER)      color_d = C_OVER;
            else if (frog_pix)          color_d = (state_q == S_PLAY) ? C_FROG : C_DEAD;
            else if (car_pix)           color_d = C_CAR;
            else if (pix_row == 4'd0)   color_d = C_GOAL;
            else if (pix_road)          color_d = C_ROAD;
        end
    end

    logic        frog_hit;
    logic [1:0]  frog_lane;
    logic [10:0] fx, fcx, fend;

    // Half-open spans: a car ending exactly at the frog's left edge is not a hit.
    always_comb begin
        frog_lane = 2'(row_q - 4'd10);
        fx        = 11'(col_q) * 11'(CELL);
        fcx       = {1'b0, car_q[frog_lane]};
        fend      = fcx + 11'(CAR_W);
        frog_hit  = (row_q >= 4'd10) && (row_q <= 4'd13) &&
                    (((fcx < fx + 11'(CELL)) && (fx < fend)) ||
                     ((fend > 11'(H_ACTIVE)) && (fx < fend - 11'(H_ACTIVE))));
    end

    always_comb begin
        state_d = state_q;
        move_d  = move_q;
        col_d   = col_q;
        row_d   = row_q;
        death_d = death_q;
        score_d = score_q;
        lives_d = lives_q;
        for (int l = 0; l < 4; l++) car_d[l] = car_q[l];
        btn_d    = {btn_up, btn_down, btn_left, btn_right};
        btn_rise = btn_d & ~btn_q;
        vs_d     = (next_y == 10'(V_ACTIVE)) && (next_x == 10'd0);
        tick_d   = vs_d && !vs_q;
        check_d  = tick_q;

        if (tick_q) begin
            for (int l = 0; l < 4; l++) car_d[l] = car_step(car_q[l], l);
            move_d = MV_NONE;
            if (state_q == S_PLAY) begin
                case (move_q)
                    MV_UP:    if (row_q != 4'd0)              row_d = row_q - 4'd1;
                    MV_DOWN:  if (row_q != 4'(ROWS - 1))      row_d = row_q + 4'd1;
                    MV_LEFT:  if (col_q != 5'd0)              col_d = col_q - 5'd1;
                    MV_RIGHT: if (col_q != 5'(COLS - 1))      col_d = col_q + 5'd1;
                    default: ;
                endcase
            end else if (state_q == S_DEAD) begin
                death_d = death_q + 1'b1;
                if (death_d == DW'(DEATH_FRAMES)) begin
                    col_d   = 5'(START_COL);
                    row_d   = 4'(START_ROW);
                    state_d = (lives_q != 4'd0) ? S_PLAY : S_OVER;
                end
            end
        end

        if (state_q == S_PLAY && btn_rise != 4'd0) begin
            if (btn_rise[3])      move_d = MV_UP;
            else if (btn_rise[2]) move_d = MV_DOWN;
            else if (btn_rise[1]) move_d = MV_LEFT;
            else                  move_d = MV_RIGHT;
        end

        if (check_q && state_q == S_PLAY) begin
            if (row_q == 4'd0) begin
                if (score_q != 8'hFF) score_d = score_q + 8'd1;
                col_d = 5'(START_COL);
                row_d = 4'(START_ROW);
            end else if (frog_hit) begin
                lives_d = lives_q - 4'd1;
                state_d = S_DEAD;
                death_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_PLAY;
            move_q  <= MV_NONE;
            btn_q   <= '0;
            col_q   <= 5'(START_COL);
            row_q   <= 4'(START_ROW);
            for (int l = 0; l < 4; l++) car_q[l] <= 10'(l * (H_ACTIVE / 4));
            death_q <= '0;
            score_q <= '0;
            lives_q <= 4'(START_LIVES);
            color_q <= '0;
            vs_q    <= 1'b0;
            tick_q  <= 1'b0;
            check_q <= 1'b0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            btn_q   <= btn_d;
            col_q   <= col_d;
            row_q   <= row_d;
            for (int l = 0; l < 4; l++) car_q[l] <= car_d[l];
            death_q <= death_d;
            score_q <= score_d;
            lives_q <= lives_d;
            color_q <= color_d;
            vs_q    <= vs_d;
            tick_q  <= tick_d;
            check_q <= check_d;
        end
    end

    assign color_out  = color_q;
    assign frame_tick = tick_q;
    assign score      = score_q;
    assign lives      = lives_q;
endmodule

// File: tb/tb_frog_renderer.sv
// tb/tb_frog_renderer.sv - randomized bench for frog_renderer against a frame-level game model
module tb_frog_renderer;
    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] next_x, next_y;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic [7:0] color_out;
    logic       frame_tick;
    logic [7:0] score;
    logic [3:0] lives;

    always #20 clock = ~clock;

    frog_renderer dut (
        .clock(clock), .reset(reset), .next_x(next_x), .next_y(next_y),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .color_out(color_out), .frame_tick(frame_tick), .score(score), .lives(lives)
    );

    localparam int PLAY = 0, DEAD = 1, OVER = 2;

    int n_asserts = 0;
    int n_fail    = 0;
    int m_col, m_row, m_state, m_lives, m_score, m_cnt, m_pend;
    int m_car [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 9; m_row = 14; m_state = PLAY; m_lives = 3; m_score = 0; m_cnt = 0; m_pend = 0;
        for (int l = 0; l < 4; l++) m_car[l] = 160 * l;
    endtask

    function automatic bit car_covers(input int lane, input int x);
        return ((x - m_car[lane] + 640) % 640) < 64;
    endfunction

    function automatic bit frog_overlap();
        if (m_row < 10 || m_row > 13) return 0;
        for (int p = m_col * 32; p < m_col * 32 + 32; p++)
            if (car_covers(m_row - 10, p)) return 1;
        return 0;
    endfunction

    function automatic int mcolor(input int x, input int y);
        int r;
        if (x >= 640 || y >= 480) return 0;
        if (m_state == OVER) return 8'hE0;
        r = y / 32;
        if (x / 32 == m_col && r == m_row) return (m_state == PLAY) ? 8'h1C : 8'hFC;
        if (r >= 10 && r <= 13 && car_covers(r - 10, x)) return 8'hE0;
        if (r == 0) return 8'h03;
        if (r >= 10 && r <= 13) return 8'h49;
        return 0;
    endfunction

    task automatic model_frame();
        if (m_state == PLAY) begin
            case (m_pend)
                1: if (m_row > 0)  m_row--;
                2: if (m_row < 14) m_row++;
                3: if (m_col > 0)  m_col--;
                4: if (m_col < 19) m_col++;
                default: ;
            endcase
        end
        m_pend = 0;
        for (int l = 0; l < 4; l++)
            m_car[l] = (l % 2 == 0) ? (m_car[l] + l + 1) % 640 : (m_car[l] - (l + 1) + 640) % 640;
        if (m_state == DEAD) begin
            m_cnt++;
            if (m_cnt == 30) begin
                m_col = 9; m_row = 14;
                m_state = (m_lives > 0) ? PLAY : OVER;
            end
        end
        if (m_state == PLAY) begin
            if (m_row == 0) begin
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_col = 9; m_row = 14;
            end else if (frog_overlap()) begin
                m_lives--; m_state = DEAD; m_cnt = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic check_pix(input int x, input int y, input string tag);
        next_x = 10'(x); next_y = 10'(y);
        step();
        chk(tag, 32'(color_out), mcolor(x, y));
    endtask

    task automatic rand_pix();
        int x, y;
        y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(320, 447)) : int'($urandom_range(0, 524));
        x = (y == 480) ? int'($urandom_range(1, 799)) : int'($urandom_range(0, 799));
        check_pix(x, y, "rand_pixel");
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        step();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        step();
        if (m_state == PLAY && (u | d | l | r)) m_pend = u ? 1 : d ? 2 : l ? 3 : 4;
    endtask

    task automatic do_frame();
        next_x = 10'd0; next_y = 10'd480;
        step();
        chk("frame_tick_rise", 32'(frame_tick), 1);
        chk("vblank_black", 32'(color_out), 0);
        step();
        chk("frame_tick_once", 32'(frame_tick), 0);
        step();
        next_y = 10'd0;
        model_frame();
        chk("lives", 32'(lives), m_lives);
        chk("score", 32'(score), m_score);
        check_pix(m_col * 32 + 16, m_row * 32 + 16, "frog_pixel");
        repeat (3) rand_pix();
    endtask

    initial begin
        int guard;
        int r;
        reset = 1'b1; next_x = '0; next_y = '0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        model_reset();
        step(); step();
        chk("reset_color", 32'(color_out), 0);
        chk("reset_tick", 32'(frame_tick), 0);
        chk("reset_score", 32'(score), 0);
        chk("reset_lives", 32'(lives), 3);
        reset = 1'b0;

        for (int x = 0; x < 640; x++) check_pix(x, 0, "goal_sweep");
        check_pix(700, 0, "hblank");
        check_pix(100, 500, "vblank");
        for (int x = 0; x < 640; x += 4) check_pix(x, 330, "lane0_sweep");
        for (int x = 0; x < 640; x += 4) check_pix(x, 430, "lane3_sweep");
        for (int x = 0; x < 640; x += 16) check_pix(x, 460, "start_row_sweep");

        press(1, 0, 0, 0);
        do_frame();
        check_pix(288, 416, "up_once");
        do_frame();
        check_pix(288, 416, "no_repeat");
        press(0, 1, 0, 0);
        do_frame();

        for (int i = 0; i < 10; i++) begin
            press(0, 0, 1, 0);
            do_frame();
            check_pix(16, 464, "left_walk");
        end
        press(0, 1, 0, 1);
        do_frame();
        check_pix(16, 464, "down_prio_clamp");
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        do_frame();
        check_pix(48, 464, "newest_wins");
        for (int i = 0; i < 8; i++) begin press(0, 0, 0, 1); do_frame(); end

        for (int i = 0; i < 14; i++) begin
            press(1, 0, 0, 0);
            do_frame();
        end

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) press(r[3], r[2], r[1], r[0]);
            do_frame();
        end

        guard = 0;
        while (m_state != OVER && guard < 2000) begin
            if (m_state == PLAY) begin
                if (m_row < 13) press(0, 1, 0, 0);
                else if (m_row > 13) press(1, 0, 0, 0);
            end
            do_frame();
            guard++;
        end
        next_x = 10'd5; next_y = 10'd5;
        step();
        chk("game_over_pixel", 32'(color_out), 8'hE0);
        chk("game_over_lives", 32'(lives), 0);
        press(1, 0, 0, 0);
        do_frame();
        press(0, 0, 1, 0);
        do_frame();

        reset = 1'b1; step(); reset = 1'b0;
        model_reset();
        chk("rst_lives", 32'(lives), 3);
        chk("rst_score", 32'(score), 0);
        check_pix(300, 460, "rst_frog");
        check_pix(50, 10, "rst_goal");

        guard = 0;
        while (m_state != DEAD && guard < 400) begin
            if (m_state == PLAY && m_row > 13) press(1, 0, 0, 0);
            do_frame();
            guard++;
        end
        chk("dead_lives", 32'(lives), 2);
        do_frame(); do_frame();
        next_x = 10'd0; next_y = 10'd480;
        reset = 1'b1; step(); reset = 1'b0;
        next_y = 10'd0;
        model_reset();
        chk("mid_dead_rst_lives", 32'(lives), 3);
        chk("mid_dead_rst_tick", 32'(frame_tick), 0);
        check_pix(300, 460, "mid_dead_rst_frog");
        do_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
